// File: rtl/wishbone_pkg.sv
// wishbone_pkg: shared bus defaults and responder FSM state encoding
package wishbone_pkg;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADR_WIDTH  = 8;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/wishbone_regfile.sv
// wishbone_regfile: 16-word byte-enable register file with async clear and registered read
module wishbone_regfile #(
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [3:0]      wadr,
  input  logic [DW/8-1:0] sel,
  input  logic [DW-1:0]   wdat,
  input  logic            re,
  input  logic [3:0]      radr,
  output logic [DW-1:0]   rdat
);
  logic [DW-1:0] mem_q [16];
  // storage: byte-lane writes, all words cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < DW/8; b++) if (sel[b]) mem_q[wadr][b*8 +: 8] <= wdat[b*8 +: 8];
    end
  end
  // read port: word presented only in the cycle after re, zero otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdat <= '0;
    else rdat <= re ? mem_q[radr] : '0;
  end
endmodule

// File: rtl/wishbone_slave_mem.sv
// wishbone_slave_mem: Wishbone classic single-transfer memory responder with wait states
module wishbone_slave_mem
  import wishbone_pkg::*;
#(
  parameter int                        DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int                        ADR_WIDTH   = DEF_ADR_WIDTH,
  parameter logic [ADR_WIDTH-1:0]      BASE_ADR    = 'hB0,
  parameter int                        WAIT_STATES = 1
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    CYC_I,
  input  logic                    STB_I,
  input  logic                    WE_I,
  input  logic [ADR_WIDTH-1:0]    ADR_I,
  input  logic [DATA_WIDTH/8-1:0] SEL_I,
  input  logic [DATA_WIDTH-1:0]   DAT_I,
  output logic [DATA_WIDTH-1:0]   DAT_O,
  output logic                    ACK_O,
  output logic                    ERR_O
);
  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    we_q;
  logic [ADR_WIDTH-1:0]    adr_q;
  logic [DATA_WIDTH/8-1:0] sel_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic                    ack_q, err_q;
  logic                    req, hit_q, in_idle;
  logic [ADR_WIDTH-1:0]    w_adr;
  logic [DATA_WIDTH/8-1:0] w_sel;
  logic [DATA_WIDTH-1:0]   w_dat;
  logic                    w_we, w_go, wr_en, rd_en;
  assign req     = CYC_I & STB_I;
  assign hit_q   = adr_q[7:4] == BASE_ADR[7:4];
  assign in_idle = state_q == IDLE;
  // the write commits on the RESP-entry edge, which is the capture edge itself when there are no wait states
  always_comb begin
    w_adr = in_idle ? ADR_I : adr_q;
    w_sel = in_idle ? SEL_I : sel_q;
    w_dat = in_idle ? DAT_I : dat_q;
    w_we  = in_idle ? WE_I : we_q;
    w_go  = in_idle ? (WAIT_STATES == 0) : (state_q == WAIT && cnt_q == 4'd0);
    wr_en = req && w_go && w_we && w_adr[7:4] == BASE_ADR[7:4];
    rd_en = state_q == RESP && hit_q && !we_q;
  end
  // responder FSM: capture, count wait states, terminate with a one-cycle ACK/ERR
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (req) begin
          we_q    <= WE_I;
          adr_q   <= ADR_I;
          sel_q   <= SEL_I;
          dat_q   <= DAT_I;
          cnt_q   <= WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
          state_q <= WAIT_STATES == 0 ? RESP : WAIT;
        end
        WAIT: if (!req) state_q <= IDLE;
          else if (cnt_q == 4'd0) state_q <= RESP;
          else cnt_q <= cnt_q - 4'd1;
        RESP: begin
          ack_q   <= hit_q;
          err_q   <= !hit_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ACK_O = ack_q;
  assign ERR_O = err_q;
  wishbone_regfile #(.DW(DATA_WIDTH)) u_regfile (
    .clk  (CLK_I),
    .rst_n(RST_I),
    .we   (wr_en),
    .wadr (w_adr[3:0]),
    .sel  (w_sel),
    .wdat (w_dat),
    .re   (rd_en),
    .radr (adr_q[3:0]),
    .rdat (DAT_O)
  );
endmodule

// File: doc/wishbone_slave_mem.md
WISHBONE_SLAVE_MEM -- requirements
Module: wishbone_slave_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter ADR_WIDTH, default 8, address bus width.
REQ-003 SHALL have parameter BASE_ADR, default 8'hB0, slave base; ADR_I[7:4] must equal BASE_ADR[7:4].
REQ-004 SHALL have parameter WAIT_STATES, default 1, extra cycles inserted before ACK_O/ERR_O (0..15).
REQ-005 SHALL have port CLK_I, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port RST_I, input, 1, reset, asynchronous assert, active-low.
REQ-007 SHALL have port CYC_I, input, 1, bus cycle in progress.
REQ-008 SHALL have port STB_I, input, 1, transfer strobe.
REQ-009 SHALL have port WE_I, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port ADR_I, input, ADR_WIDTH, byte-independent word address; ADR_I[3:0] indexes 16 words.
REQ-011 SHALL have port SEL_I, input, DATA_WIDTH/8, byte-lane enables for writes.
REQ-012 SHALL have port DAT_I, input, DATA_WIDTH, write data.
REQ-013 SHALL have port DAT_O, output, DATA_WIDTH, read data, valid only while ACK_O=1.
REQ-014 SHALL have port ACK_O, output, 1, normal termination, one-cycle pulse.
REQ-015 SHALL have port ERR_O, output, 1, error termination (decode miss), one-cycle pulse.

Function
REQ-016 SHALL implement Wishbone classic single-transfer responder with FSM states IDLE, WAIT, RESP.
REQ-017 IDLE: on CYC_I&STB_I SHALL capture WE_I, ADR_I, SEL_I, DAT_I; go WAIT if WAIT_STATES>0, else RESP; load wait counter with WAIT_STATES-1.
REQ-018 WAIT: SHALL decrement counter each cycle; at 0 go RESP.
REQ-019 WAIT: if CYC_I or STB_I drops (master abort), SHALL return to IDLE, no write, no ACK_O/ERR_O.
REQ-020 RESP: SHALL drive exactly one of ACK_O/ERR_O high for one cycle, then go IDLE unconditionally.
REQ-021 Latency from strobe-sampling edge to ACK_O/ERR_O high SHALL be WAIT_STATES+1 cycles; minimum two cycles per transfer (back-to-back strobe re-sampled in IDLE).
REQ-022 Decode miss (captured ADR[7:4] != BASE_ADR[7:4]) SHALL give ERR_O, no write, DAT_O=0.
REQ-023 Write hit SHALL update only bytes with SEL_I bit set, committed on the RESP-entry edge; SEL_I=0 completes with ACK_O and no change.
REQ-024 Read hit SHALL present mem[ADR[3:0]] on DAT_O registered with ACK_O; DAT_O=0 in all other cycles.
REQ-025 Outputs SHALL be registered; no combinational path from inputs to ACK_O/ERR_O/DAT_O.
REQ-026 Captured request SHALL be used; input changes after capture SHALL be ignored, except REQ-019.

Reset
REQ-027 RST_I=0 SHALL immediately force state IDLE, counter 0, ACK_O=0, ERR_O=0, DAT_O=0, all 16 words 0.
REQ-028 Reset mid-transfer SHALL discard it, no write, no termination; first strobe after release is a fresh transfer.

Structure
REQ-029 SHALL take DATA_WIDTH/ADR_WIDTH defaults and the FSM state enum from shared package wishbone_pkg.
REQ-030 SHALL instantiate one sub-module wishbone_regfile (16 x DATA_WIDTH, byte-enable write, async-clear, registered read).

Verification
REQ-031 Reset: RST_I=0 then released -> ACK_O=ERR_O=0, DAT_O=0; read of 0xB6 returns 0.
REQ-032 Write 0x123ababaabcdef90 to 0xB6, SEL_I=8'hFF, WAIT_STATES=1 -> ACK_O exactly 2 cycles after strobe, one cycle wide; read 0xB6 returns 0x123ababaabcdef90.
REQ-033 Byte-lane write 0xabcdefabcdefabcd to 0xB6, SEL_I=8'h0F -> read returns 0x123ababaabcdefabcd's low 4 bytes merged = 0x123ababacdefabcd.
REQ-034 Access 0xC6 (write 0x1234567812345678, then read) -> ERR_O pulse, no ACK_O, DAT_O=0, 0xB6 contents unchanged.
REQ-035 Abort: WAIT_STATES=3, write 0xB2 then drop STB_I after 1 cycle -> no ACK_O/ERR_O, 0xB2 still 0.
REQ-036 Reset asserted during WAIT of write to 0xB4 -> outputs 0 immediately, 0xB4 reads 0 after release.
